// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-bus signals of the port arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_port_arbiter_if;
    logic        fReq;
    logic [31:0] fAddr;
    logic        fDone;
    logic [31:0] fRData;
    logic        dReq;
    logic [31:0] dAddr;
    logic [1:0]  dWidth;
    logic [31:0] dWData;
    logic        dIsStore;
    logic        dIsLoad;
    logic        dIsLoadUnsigned;
    logic        dDone;
    logic [31:0] dRData;
    logic        dMisaligned;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memWe;
    logic [3:0]  memBe;
    logic [31:0] memWData;
    logic        memGrant;
    logic        memRValid;
    logic [31:0] memRData;
    modport slave (
        input  fReq, fAddr, dReq, dAddr, dWidth, dWData, dIsStore, dIsLoad, dIsLoadUnsigned,
               memGrant, memRValid, memRData,
        output fDone, fRData, dDone, dRData, dMisaligned, memReq, memAddr, memWe, memBe, memWData
    );
    modport master (
        output fReq, fAddr, dReq, dAddr, dWidth, dWData, dIsStore, dIsLoad, dIsLoadUnsigned,
               memGrant, memRValid, memRData,
        input  fDone, fRData, dDone, dRData, dMisaligned, memReq, memAddr, memWe, memBe, memWData
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory bus between instruction fetch and load/store,
// one outstanding transaction at a time, with byte-lane encoding and load extension.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W = 3
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave ports
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE_D} stateT;
    stateT state;
    logic ownerFetch;
    logic [CNT_W-1:0] starveCnt;
    logic [1:0] off;
    logic fetchWins, dActive, dMis;
    logic [3:0] beBase;
    logic [31:0] wLanes, shifted, loadExt;
    always_comb begin
        off = ports.dAddr[1:0];
        fetchWins = ports.fReq && (!ports.dReq || starveCnt == CNT_W'(STARVE_LIMIT));
        dActive = (ports.dIsLoad || ports.dIsStore) && ports.dWidth != 2'd0;
        dMis = (ports.dWidth == 2'd2 && off[0]) || (ports.dWidth == 2'd3 && off != 2'd0);
        beBase = ports.dWidth == 2'd1 ? 4'b0001 : ports.dWidth == 2'd2 ? 4'b0011 : 4'b1111;
        wLanes = ports.dWidth == 2'd1 ? {4{ports.dWData[7:0]}}
               : ports.dWidth == 2'd2 ? {2{ports.dWData[15:0]}} : ports.dWData;
        shifted = ports.memRData >> {off, 3'b000};
        loadExt = ports.dWidth == 2'd1 ? {{24{shifted[7] & ~ports.dIsLoadUnsigned}}, shifted[7:0]}
                : ports.dWidth == 2'd2 ? {{16{shifted[15] & ~ports.dIsLoadUnsigned}}, shifted[15:0]}
                : ports.memRData;
    end
    // Requesters hold their fields until done, so completion reads them straight from the ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ownerFetch <= 1'b0;
            starveCnt <= '0;
            ports.fDone <= 1'b0;
            ports.fRData <= '0;
            ports.dDone <= 1'b0;
            ports.dRData <= '0;
            ports.dMisaligned <= 1'b0;
            ports.memReq <= 1'b0;
            ports.memAddr <= '0;
            ports.memWe <= 1'b0;
            ports.memBe <= '0;
            ports.memWData <= '0;
        end else begin
            ports.fDone <= 1'b0;
            ports.dDone <= 1'b0;
            if (!ports.fReq) starveCnt <= '0;
            case (state)
                IDLE: if (fetchWins) begin
                    ownerFetch <= 1'b1;
                    starveCnt <= '0;
                    ports.memReq <= 1'b1;
                    ports.memAddr <= {ports.fAddr[31:2], 2'b00};
                    ports.memWe <= 1'b0;
                    ports.memBe <= 4'b1111;
                    ports.memWData <= '0;
                    state <= REQ;
                end else if (ports.dReq) begin
                    ownerFetch <= 1'b0;
                    if (ports.fReq) starveCnt <= starveCnt + 1'b1;
                    if (!dActive || dMis) state <= DONE_D;
                    else begin
                        ports.memReq <= 1'b1;
                        ports.memAddr <= {ports.dAddr[31:2], 2'b00};
                        ports.memWe <= ports.dIsStore;
                        ports.memBe <= ports.dIsStore ? beBase << off : 4'b1111;
                        ports.memWData <= ports.dIsStore ? wLanes : '0;
                        state <= REQ;
                    end
                end
                REQ: if (ports.memGrant) begin
                    ports.memReq <= 1'b0;
                    state <= RESP;
                end
                RESP: if (ports.memRValid) begin
                    state <= IDLE;
                    if (ownerFetch) begin
                        ports.fDone <= 1'b1;
                        ports.fRData <= ports.memRData;
                    end else begin
                        ports.dDone <= 1'b1;
                        ports.dMisaligned <= 1'b0;
                        ports.dRData <= ports.dIsStore ? '0 : loadExt;
                    end
                end
                default: begin
                    ports.dDone <= 1'b1;
                    ports.dMisaligned <= dActive && dMis;
                    ports.dRData <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
